rs_branch: RTL and testbench

Branch reservation station feeding the branch execution unit. Holds up to `RS_ENT` dispatched branch/jump micro-ops, captures their source operands from the writeback broadcast buses, and issues at most one ready entry per cycle. The issued fields (`ex_src1`, `ex_src2`, `pc`, `imm`, `praddr`, `opcode`, `alu_op`, `dstval`, `spectag`, `issue`) drive the branch unit's same-named inputs directly. Misprediction recovery invalidates speculative entries by spectag mask.

---
 rtl/rs_branch.sv | 196 +++++++++++++++++++
 tb/tb_rs_branch.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/rs_branch.sv
// rs_branch: branch reservation station with writeback wakeup and spectag kill.
// Define RS_BRANCH_OLDEST_FIRST_EN for age-matrix oldest-ready select.
module rs_branch #(
  parameter int RS_ENT       = 4,
  parameter int DATA_LEN     = 32,
  parameter int ADDR_LEN     = 32,
  parameter int RRF_SEL      = 6,
  parameter int SPECTAG_LEN  = 5,
  parameter int ALU_OP_WIDTH = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    dp_we,
  input  logic [DATA_LEN-1:0]     dp_src1,
  input  logic [DATA_LEN-1:0]     dp_src2,
  input  logic                    dp_valid1,
  input  logic                    dp_valid2,
  input  logic [ADDR_LEN-1:0]     dp_pc,
  input  logic [ADDR_LEN-1:0]     dp_praddr,
  input  logic [DATA_LEN-1:0]     dp_imm,
  input  logic [6:0]              dp_opcode,
  input  logic [ALU_OP_WIDTH-1:0] dp_alu_op,
  input  logic                    dp_dstval,
  input  logic [SPECTAG_LEN-1:0]  dp_spectag,
  input  logic                    wb_we0,
  input  logic                    wb_we1,
  input  logic [RRF_SEL-1:0]      wb_tag0,
  input  logic [RRF_SEL-1:0]      wb_tag1,
  input  logic [DATA_LEN-1:0]     wb_data0,
  input  logic [DATA_LEN-1:0]     wb_data1,
  input  logic                    kill,
  input  logic [SPECTAG_LEN-1:0]  kill_mask,
  output logic                    full,
  output logic                    issue,
  output logic [DATA_LEN-1:0]     ex_src1,
  output logic [DATA_LEN-1:0]     ex_src2,
  output logic [DATA_LEN-1:0]     imm,
  output logic [ADDR_LEN-1:0]     pc,
  output logic [ADDR_LEN-1:0]     praddr,
  output logic [6:0]              opcode,
  output logic [ALU_OP_WIDTH-1:0] alu_op,
  output logic                    dstval,
  output logic [SPECTAG_LEN-1:0]  spectag
);

  localparam int SW = (RS_ENT > 1) ? $clog2(RS_ENT) : 1;

  typedef struct packed {
    logic [ADDR_LEN-1:0]     pc;
    logic [ADDR_LEN-1:0]     praddr;
    logic [DATA_LEN-1:0]     imm;
    logic [6:0]              opcode;
    logic [ALU_OP_WIDTH-1:0] alu_op;
    logic                    dstval;
    logic [SPECTAG_LEN-1:0]  spectag;
  } pay_t;

  logic [RS_ENT-1:0] busy_q, busy_d;
  logic [RS_ENT-1:0] v1_q, v1_d, v2_q, v2_d;
  logic [RS_ENT-1:0][DATA_LEN-1:0] src1_q, src1_d;
  logic [RS_ENT-1:0][DATA_LEN-1:0] src2_q, src2_d;
  pay_t [RS_ENT-1:0] pay_q, pay_d;

  logic [RS_ENT-1:0] kill_hit, ready;
  logic [SW-1:0] dp_idx, sel_idx;
  logic dp_go;

  // Port 0 has priority when both broadcasts carry the same tag.
  function automatic logic [DATA_LEN:0] grab(
    input logic v,
    input logic [DATA_LEN-1:0] s
  );
    if (v)
      return {1'b1, s};
    if (wb_we0 && s[RRF_SEL-1:0] == wb_tag0)
      return {1'b1, wb_data0};
    if (wb_we1 && s[RRF_SEL-1:0] == wb_tag1)
      return {1'b1, wb_data1};
    return {1'b0, s};
  endfunction

  assign full  = &busy_q;
  assign dp_go = dp_we & ~full;

  always_comb begin
    for (int i = 0; i < RS_ENT; i++) begin
      kill_hit[i] = kill &
        (|(pay_q[i].spectag & kill_mask));
    end
    ready = busy_q & v1_q & v2_q & ~kill_hit;
  end

  always_comb begin
    dp_idx = '0;
    for (int i = RS_ENT - 1; i >= 0; i--) begin
      if (!busy_q[i]) dp_idx = SW'(i);
    end
  end

`ifdef RS_BRANCH_OLDEST_FIRST_EN
  // age_q[i][j] set: entry i is older than entry j.
  logic [RS_ENT-1:0][RS_ENT-1:0] age_q, age_d;
  logic older;

  always_comb begin
    age_d = age_q;
    if (dp_go) begin
      age_d[dp_idx] = '0;
      for (int j = 0; j < RS_ENT; j++) begin
        if (SW'(j) != dp_idx) age_d[j][dp_idx] = busy_q[j];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) age_q <= '0;
    else        age_q <= age_d;
  end

  always_comb begin
    sel_idx = '0;
    issue   = 1'b0;
    older   = 1'b0;
    for (int i = 0; i < RS_ENT; i++) begin
      older = ready[i];
      for (int j = 0; j < RS_ENT; j++) begin
        if (j != i && ready[j] && !age_q[i][j]) older = 1'b0;
      end
      if (older) begin
        sel_idx = SW'(i);
        issue   = 1'b1;
      end
    end
  end
`else
  always_comb begin
    sel_idx = '0;
    issue   = 1'b0;
    for (int i = RS_ENT - 1; i >= 0; i--) begin
      if (ready[i]) begin
        sel_idx = SW'(i);
        issue   = 1'b1;
      end
    end
  end
`endif

  always_comb begin
    busy_d = busy_q;
    pay_d  = pay_q;
    for (int i = 0; i < RS_ENT; i++) begin
      {v1_d[i], src1_d[i]} = grab(v1_q[i], src1_q[i]);
      {v2_d[i], src2_d[i]} = grab(v2_q[i], src2_q[i]);
    end
    if (issue) busy_d[sel_idx] = 1'b0;
    if (dp_go) begin
      busy_d[dp_idx] = 1'b1;
      {v1_d[dp_idx], src1_d[dp_idx]} = grab(dp_valid1, dp_src1);
      {v2_d[dp_idx], src2_d[dp_idx]} = grab(dp_valid2, dp_src2);
      pay_d[dp_idx] = '{pc: dp_pc, praddr: dp_praddr,
                        imm: dp_imm, opcode: dp_opcode,
                        alu_op: dp_alu_op, dstval: dp_dstval,
                        spectag: dp_spectag};
    end
    // Uses the next-state spectag so a same-cycle dispatch is squashed too.
    if (kill) begin
      for (int i = 0; i < RS_ENT; i++) begin
        if (|(pay_d[i].spectag & kill_mask)) busy_d[i] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) busy_q <= '0;
    else        busy_q <= busy_d;
  end

  always_ff @(posedge clk) begin
    v1_q   <= v1_d;
    v2_q   <= v2_d;
    src1_q <= src1_d;
    src2_q <= src2_d;
    pay_q  <= pay_d;
  end

  assign ex_src1 = src1_q[sel_idx];
  assign ex_src2 = src2_q[sel_idx];
  assign pc      = pay_q[sel_idx].pc;
  assign praddr  = pay_q[sel_idx].praddr;
  assign imm     = pay_q[sel_idx].imm;
  assign opcode  = pay_q[sel_idx].opcode;
  assign alu_op  = pay_q[sel_idx].alu_op;
  assign dstval  = pay_q[sel_idx].dstval;
  assign spectag = pay_q[sel_idx].spectag;

endmodule

// File: tb/tb_rs_branch.sv
// tb_rs_branch: directed steps with an issue scoreboard for rs_branch.
// Ordering expectation follows RS_BRANCH_OLDEST_FIRST_EN.
module tb_rs_branch;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        dp_we = 1'b0;
  logic [31:0] dp_src1 = '0, dp_src2 = '0;
  logic        dp_valid1 = 1'b0, dp_valid2 = 1'b0;
  logic [31:0] dp_pc = '0, dp_praddr = '0, dp_imm = '0;
  logic [6:0]  dp_opcode = '0;
  logic [3:0]  dp_alu_op = '0;
  logic        dp_dstval = 1'b0;
  logic [4:0]  dp_spectag = '0;
  logic        wb_we0 = 1'b0, wb_we1 = 1'b0;
  logic [5:0]  wb_tag0 = '0, wb_tag1 = '0;
  logic [31:0] wb_data0 = '0, wb_data1 = '0;
  logic        kill = 1'b0;
  logic [4:0]  kill_mask = '0;
  logic        full, issue, dstval;
  logic [31:0] ex_src1, ex_src2, imm, pc, praddr;
  logic [6:0]  opcode;
  logic [3:0]  alu_op;
  logic [4:0]  spectag;

  always #5 clk = ~clk;

  rs_branch dut (
    .clk(clk), .reset(reset), .dp_we(dp_we),
    .dp_src1(dp_src1), .dp_src2(dp_src2),
    .dp_valid1(dp_valid1), .dp_valid2(dp_valid2),
    .dp_pc(dp_pc), .dp_praddr(dp_praddr), .dp_imm(dp_imm),
    .dp_opcode(dp_opcode), .dp_alu_op(dp_alu_op),
    .dp_dstval(dp_dstval), .dp_spectag(dp_spectag),
    .wb_we0(wb_we0), .wb_we1(wb_we1),
    .wb_tag0(wb_tag0), .wb_tag1(wb_tag1),
    .wb_data0(wb_data0), .wb_data1(wb_data1),
    .kill(kill), .kill_mask(kill_mask),
    .full(full), .issue(issue),
    .ex_src1(ex_src1), .ex_src2(ex_src2), .imm(imm),
    .pc(pc), .praddr(praddr), .opcode(opcode),
    .alu_op(alu_op), .dstval(dstval), .spectag(spectag)
  );

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] s1;
    logic [31:0] s2;
  } exp_t;

  exp_t sb[$];
  bit   sb_en = 1'b0;
  int   checks = 0;
  int   passed = 0;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
  endtask

  task automatic mon();
    exp_t e;
    if (sb_en && issue === 1'b1) begin
      if (sb.size() == 0) begin
        chk("spurious_issue", {31'b0, issue}, 32'd0);
      end else begin
        e = sb.pop_front();
        chk("iss_pc", pc, e.pc);
        chk("iss_src1", ex_src1, e.s1);
        chk("iss_src2", ex_src2, e.s2);
        chk("iss_praddr", praddr, e.pc + 32'd4);
        chk("iss_imm", imm, ~e.pc);
      end
    end
  endtask

  task automatic step();
    @(negedge clk);
    mon();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    dp_we = 1'b0;
    wb_we0 = 1'b0;
    wb_we1 = 1'b0;
    kill = 1'b0;
    kill_mask = '0;
  endtask

  task automatic dp(input logic [31:0] p, input logic [31:0] s1,
                    input logic v1, input logic [31:0] s2,
                    input logic v2, input logic [4:0] st);
    dp_we = 1'b1;
    dp_pc = p;
    dp_praddr = p + 32'd4;
    dp_imm = ~p;
    dp_src1 = s1;
    dp_valid1 = v1;
    dp_src2 = s2;
    dp_valid2 = v2;
    dp_spectag = st;
    dp_opcode = 7'h63;
    dp_alu_op = 4'h1;
    dp_dstval = 1'b0;
  endtask

  task automatic push(input logic [31:0] p, input logic [31:0] s1,
                      input logic [31:0] s2);
    sb.push_back('{pc: p, s1: s1, s2: s2});
  endtask

  task automatic drain(input string tag);
    for (int k = 0; k < 12 && sb.size() != 0; k++) step();
    chk(tag, 32'(sb.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    #1 reset = 1'b0;
    repeat (2) step();
    chk("rst_full", {31'b0, full}, 32'd0);
    chk("rst_issue", {31'b0, issue}, 32'd0);

    // reset mid-operation
    reset = 1'b1;
    dp(32'h100, 32'h1, 1'b1, 32'h2, 1'b1, 5'b00001);
    step();
    dp(32'h110, 32'h1, 1'b1, 32'h2, 1'b1, 5'b00001);
    step();
    dp(32'h120, 32'h1, 1'b1, 32'h2, 1'b1, 5'b00001);
    step();
    idle();
    chk("pre_rst_issue", {31'b0, issue}, 32'd1);
    #2 reset = 1'b0;
    #1;
    chk("midrst_issue", {31'b0, issue}, 32'd0);
    chk("midrst_full", {31'b0, full}, 32'd0);
    step();
    reset = 1'b1;
    repeat (2) step();
    chk("postrst_issue", {31'b0, issue}, 32'd0);
    sb_en = 1'b1;

    // fill with tag-5 waiters, then drop a dispatch while full
    for (int k = 0; k < 4; k++) begin
      dp(32'h200 + 32'(16 * k), 32'd5, 1'b0,
         32'h50 + 32'(k), 1'b1, 5'b00001);
      step();
    end
    idle();
    chk("fill_full", {31'b0, full}, 32'd1);
    dp(32'h240, 32'h77, 1'b1, 32'h88, 1'b1, 5'b00001);
    step();
    idle();
    chk("drop_full", {31'b0, full}, 32'd1);
    chk("drop_issue", {31'b0, issue}, 32'd0);
    for (int k = 0; k < 4; k++)
      push(32'h200 + 32'(16 * k), 32'h1234, 32'h50 + 32'(k));
    wb_we0 = 1'b1;
    wb_tag0 = 6'd5;
    wb_data0 = 32'h1234;
    step();
    idle();
    chk("wake_issue", {31'b0, issue}, 32'd1);
    chk("wake_src1", ex_src1, 32'h1234);
    drain("fill_drain");
    chk("drained_full", {31'b0, full}, 32'd0);

    // dispatch-time bypass on port 1
    dp(32'h300, 32'h11, 1'b1, 32'd9, 1'b0, 5'b00001);
    wb_we1 = 1'b1;
    wb_tag1 = 6'd9;
    wb_data1 = 32'hBEEF;
    push(32'h300, 32'h11, 32'hBEEF);
    step();
    idle();
    chk("byp_issue", {31'b0, issue}, 32'd1);
    chk("byp_src2", ex_src2, 32'hBEEF);
    drain("byp_drain");

    // both ports broadcast the same tag
    dp(32'h400, 32'd3, 1'b0, 32'h22, 1'b1, 5'b00001);
    step();
    idle();
    wb_we0 = 1'b1; wb_tag0 = 6'd3; wb_data0 = 32'hA;
    wb_we1 = 1'b1; wb_tag1 = 6'd3; wb_data1 = 32'hB;
    push(32'h400, 32'hA, 32'h22);
    step();
    idle();
    chk("coll_src1", ex_src1, 32'hA);
    drain("coll_drain");

    // kill by mask, including a same-cycle dispatch
    dp(32'h500, 32'd7, 1'b0, 32'h1, 1'b1, 5'b00001);
    step();
    dp(32'h510, 32'd7, 1'b0, 32'h1, 1'b1, 5'b00010);
    step();
    dp(32'h520, 32'd7, 1'b0, 32'h1, 1'b1, 5'b00100);
    step();
    dp(32'h530, 32'h31, 1'b1, 32'h32, 1'b1, 5'b00010);
    kill = 1'b1;
    kill_mask = 5'b00110;
    step();
    idle();
    chk("kill_issue", {31'b0, issue}, 32'd0);
    push(32'h500, 32'h77, 32'h1);
    wb_we0 = 1'b1; wb_tag0 = 6'd7; wb_data0 = 32'h77;
    step();
    idle();
    drain("kill_drain");
    repeat (3) step();

    // killed selection falls through to the next ready entry
    dp(32'h600, 32'd8, 1'b0, 32'h61, 1'b1, 5'b00010);
    step();
    dp(32'h610, 32'd8, 1'b0, 32'h62, 1'b1, 5'b00001);
    step();
    idle();
    wb_we0 = 1'b1; wb_tag0 = 6'd8; wb_data0 = 32'h88;
    step();
    idle();
    kill = 1'b1;
    kill_mask = 5'b00010;
    push(32'h610, 32'h88, 32'h62);
    #1;
    chk("resel_issue", {31'b0, issue}, 32'd1);
    chk("resel_pc", pc, 32'h610);
    step();
    idle();
    repeat (2) step();
    chk("resel_drain", 32'(sb.size()), 32'd0);

    // older entry in slot 2, younger in slot 0
    dp(32'h7A0, 32'd10, 1'b0, 32'h1, 1'b1, 5'b00100);
    step();
    dp(32'h7B0, 32'd10, 1'b0, 32'h1, 1'b1, 5'b00100);
    step();
    dp(32'h720, 32'd11, 1'b0, 32'h72, 1'b1, 5'b00001);
    step();
    idle();
    kill = 1'b1;
    kill_mask = 5'b00100;
    step();
    idle();
    dp(32'h700, 32'd11, 1'b0, 32'h71, 1'b1, 5'b00001);
    step();
    idle();
`ifdef RS_BRANCH_OLDEST_FIRST_EN
    push(32'h720, 32'h99, 32'h72);
    push(32'h700, 32'h99, 32'h71);
`else
    push(32'h700, 32'h99, 32'h71);
    push(32'h720, 32'h99, 32'h72);
`endif
    wb_we1 = 1'b1; wb_tag1 = 6'd11; wb_data1 = 32'h99;
    step();
    idle();
    drain("order_drain");
    repeat (2) step();
    chk("end_full", {31'b0, full}, 32'd0);
    chk("end_issue", {31'b0, issue}, 32'd0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
